conv_exec_ctrl: RTL and testbench
=================================

# conv_exec_ctrl

Per-sample convolution tap sequencer. It sits between the batch controller and the output controller. On `s_init` it walks every output window of a sample and every kernel tap within each window, issuing input-buffer read addresses and weight addresses to the MAC array. It signals window boundaries with `k_init`/`k_fin`, which the output controller consumes, and signals sample completion with `s_fin`, which the batch controller consumes.

## Interface
- `LAT`, default 2: cycles from the exec of a window's last tap to its `k_fin` (MAC pipeline depth).
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_init`  in  1  start-of-sample pulse; honoured only in IDLE.
- `out_busy`  in  1  output controller cannot accept another window; stalls window boundaries.
- `id`  in  4  input channels − 1.
- `is`  in  12  words per input channel plane.
- `iw`  in  6  input row width (words).
- `ow`  in  6  output width − 1.
- `oh`  in  6  output height − 1.
- `kw`  in  4  kernel width − 1.
- `kh`  in  4  kernel height − 1.
- `exec`  out  1  tap valid; `ia` and `wa` are meaningful.
- `ia`  out  12  input buffer read address.
- `wa`  out  10  weight address.
- `k_init`  out  1  with `exec`, marks the first tap of a window.
- `k_fin`  out  1  pulse: window accumulation complete.
- `s_fin`  out  1  pulse: last window of the sample complete.
- `busy`  out  1  sample in progress.

## Operation
- Loop nest, outer to inner: `oy` 0..oh, `ox` 0..ow, `ic` 0..id, `ky` 0..kh, `kx` 0..kw.
- Addressing:
  - `ia = ic*is + (oy+ky)*iw + ox + kx`, modulo 4096.
  - `wa = ki`, where `ki` is a tap counter that restarts at 0 per window.
  - Both are computed incrementally: window base `oy*iw+ox` plus tap offset `ic*is+ky*iw+kx`. No multipliers.
- FSM states: IDLE, RUN, HOLD, DRAIN.
  - IDLE → RUN on `s_init`.
  - RUN: one tap per cycle, `exec=1`. Consecutive windows are back to back with no bubble.
  - RUN → HOLD when the next tap is the first tap of a window other than window 0 and `out_busy=1`.
  - HOLD: `exec=0`, all counters frozen. Returns to RUN the cycle after `out_busy=0`.
  - RUN → DRAIN after the last tap of the last window.
  - DRAIN → IDLE when `s_fin` fires.
- `k_fin` is produced by a LAT-deep shift of a "last tap of window" strobe. It therefore fires even while the block is in HOLD.
- `s_init` in RUN, HOLD or DRAIN is ignored.
- Out-of-range configurations wrap silently; there is no checking.
- Reset values: all outputs 0; state IDLE; counters 0; delay line cleared.

## Timing
- `s_init` sampled at edge t gives the first `exec` at cycle t+1 with `ia=0`, `wa=0`, `k_init=1`. Address outputs are registered.
- Taps per window: T = (id+1)(kh+1)(kw+1). Window n (0-based, no stalls) occupies cycles t+1+nT .. t+nT+T.
- `k_fin` fires LAT cycles after the last tap's exec cycle.
- `s_fin` fires in the same cycle as the final `k_fin`.
- `busy` is high from t+1 through the `s_fin` cycle inclusive.
- `out_busy` is sampled only at window boundaries; mid-window changes have no effect.
- `rst` mid-sample aborts immediately, with no `k_fin` or `s_fin` for the partial window.

## Configuration
- Macro: `CONV_EXEC_CTRL_BACKPROP_EN`.
- Defined:
  - Adds input port `backprop` (1 bit).
  - When `backprop=1`, `wa = T−1−ki` (rotated kernel for gradient propagation).
  - When `backprop=0`, behaviour is as below.
- Undefined: no `backprop` port, and `wa = ki` always.

## Structure
- Shared package `tiny_dnn_pkg`:
  - Constants `ADDR_W=12`, `WADR_W=10`, `CH_W=4`.
  - FSM state typedef `exec_state_t`.
- Loop counters use the existing `loop1` primitive.
- One natural sub-module: `tap_addr_gen`, the inner `ic/ky/kx` loop with its incremental offset and `ki` counter. It outputs the tap offset, `ki` and a last-tap flag.

## Test plan
- id=0, kh=kw=0, ow=oh=0, LAT=2:
  - `s_init` → one `exec` cycle with `ia=0`, `wa=0`, `k_init=1`.
  - `k_fin=s_fin=1` two cycles later.
  - `busy` high for 3 cycles.
- 3×3 kernel, id=0, iw=6, ow=oh=3:
  - Exactly 144 `exec` cycles, 16 `k_fin`, 1 `s_fin`.
  - Window (ox=2, oy=1), tap ky=2, kx=1 → `ia=21`, `wa=7`.
- id=1, is=36, 3×3 kernel: window 0, tap ic=1, ky=0, kx=0 → `ia=36`, `wa=9`, `k_init=0`.
- `out_busy` held high for 5 cycles at the window 0→1 boundary:
  - `exec` low exactly 5 cycles and `k_fin` for window 0 still fires.
  - Window 1 starts with `ia=1` and `k_init=1`; no tap is lost or duplicated.
- `rst` pulsed mid-window:
  - All outputs 0 asynchronously; no `k_fin` or `s_fin`.
  - A later `s_init` restarts from `ia=0`.
- With `CONV_EXEC_CTRL_BACKPROP_EN`, backprop=1, 3×3 kernel, id=0: `wa` sequence 8, 7, …, 0 per window; `ia` unchanged from the forward case.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared types and widths for the tiny_dnn convolution datapath.
// Imported by the sequencer, its tap generator and the loop primitive users.
package tiny_dnn_pkg;

   localparam int ADDR_W = 12;
   localparam int WADR_W = 10;
   localparam int CH_W   = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD,
      S_DRAIN
   } exec_state_t;

endpackage

// File: rtl/loop1.sv
// Single loop counter: counts 0..max, wraps to 0 on an increment at max.
// The last flag lets callers chain counters into a loop nest.
module loop1 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic [W-1:0] max,
   output logic [W-1:0] cnt,
   output logic         last
);

   assign last = (cnt == max);

   // Advance on inc, wrapping after the terminal value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc)
         cnt <= last ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/tap_addr_gen.sv
// Inner ic/ky/kx loop of one window: incremental tap offset and tap index.
// Offset is ic*is + ky*iw + kx, built from running sums rather than products.
module tap_addr_gen
   import tiny_dnn_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic [CH_W-1:0]   id,
   input  logic [ADDR_W-1:0] is,
   input  logic [5:0]        iw,
   input  logic [3:0]        kw,
   input  logic [3:0]        kh,
   output logic [ADDR_W-1:0] off,
   output logic [WADR_W-1:0] ki,
   output logic              last
);

   logic [3:0]        kx;
   logic [3:0]        ky;
   logic [CH_W-1:0]   ic;
   logic              kx_l;
   logic              ky_l;
   logic              ic_l;
   logic              ky_inc;
   logic              ic_inc;
   logic [ADDR_W-1:0] krow;
   logic [ADDR_W-1:0] ch_base;

   assign ky_inc = inc & kx_l;
   assign ic_inc = ky_inc & ky_l;
   assign last   = kx_l & ky_l & ic_l;
   assign off    = ch_base + krow + {8'd0, kx};

   loop1 #(.W(4)) u_kx (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .max (kw),
      .cnt (kx),
      .last(kx_l)
   );

   loop1 #(.W(4)) u_ky (
      .clk (clk),
      .rst (rst),
      .inc (ky_inc),
      .max (kh),
      .cnt (ky),
      .last(ky_l)
   );

   loop1 #(.W(CH_W)) u_ic (
      .clk (clk),
      .rst (rst),
      .inc (ic_inc),
      .max (id),
      .cnt (ic),
      .last(ic_l)
   );

   // Running ky*iw, cleared when the kernel row loop wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         krow <= '0;
      else if (ky_inc)
         krow <= ky_l ? '0 : krow + {6'd0, iw};
   end

   // Running ic*is, cleared when the channel loop wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ch_base <= '0;
      else if (ic_inc)
         ch_base <= ic_l ? '0 : ch_base + is;
   end

   // Tap index within the window, restarting after the last tap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ki <= '0;
      else if (inc)
         ki <= last ? '0 : ki + 1'b1;
   end

endmodule

// File: rtl/conv_exec_ctrl.sv
// Per-sample convolution tap sequencer: windows oy/ox, taps via tap_addr_gen.
// Optional CONV_EXEC_CTRL_BACKPROP_EN adds a backprop port that reverses wa.
module conv_exec_ctrl
   import tiny_dnn_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
`ifdef CONV_EXEC_CTRL_BACKPROP_EN
   input  logic              backprop,
`endif
   input  logic              s_init,
   input  logic              out_busy,
   input  logic [CH_W-1:0]   id,
   input  logic [ADDR_W-1:0] is,
   input  logic [5:0]        iw,
   input  logic [5:0]        ow,
   input  logic [5:0]        oh,
   input  logic [3:0]        kw,
   input  logic [3:0]        kh,
   output logic              exec,
   output logic [ADDR_W-1:0] ia,
   output logic [WADR_W-1:0] wa,
   output logic              k_init,
   output logic              k_fin,
   output logic              s_fin,
   output logic              busy
);

   exec_state_t       state;
   exec_state_t       nxt;
   logic              issue;
   logic [ADDR_W-1:0] off;
   logic [WADR_W-1:0] ki;
   logic              tap_last;
   logic              first_tap;
   logic              win0;
   logic              fin_tap;
   logic              win_inc;
   logic              oy_inc;
   logic [5:0]        ox;
   logic [5:0]        oy;
   logic              ox_l;
   logic              oy_l;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] win_base;
   logic [WADR_W-1:0] wa_nxt;
   logic [LAT:0]      ksr;
   logic [LAT:0]      ssr;

   assign first_tap = (ki == '0);
   assign win0      = (ox == '0) && (oy == '0);
   assign win_inc   = issue & tap_last;
   assign oy_inc    = win_inc & ox_l;
   assign fin_tap   = tap_last & ox_l & oy_l;
   assign win_base  = row_base + {6'd0, ox};
   assign busy      = (state != S_IDLE);
   assign k_fin     = ksr[LAT];
   assign s_fin     = ssr[LAT];

`ifdef CONV_EXEC_CTRL_BACKPROP_EN
   logic [WADR_W-1:0] t_cnt;

   // Rotated kernel index: T-1-ki, with T taken mod 2^WADR_W.
   always_comb begin
      t_cnt = (WADR_W'(id) + 1'b1)
            * (WADR_W'(kh) + 1'b1)
            * (WADR_W'(kw) + 1'b1);
      wa_nxt = backprop ? (t_cnt - 1'b1 - ki) : ki;
   end
`else
   assign wa_nxt = ki;
`endif

   tap_addr_gen u_tap (
      .clk (clk),
      .rst (rst),
      .inc (issue),
      .id  (id),
      .is  (is),
      .iw  (iw),
      .kw  (kw),
      .kh  (kh),
      .off (off),
      .ki  (ki),
      .last(tap_last)
   );

   loop1 #(.W(6)) u_ox (
      .clk (clk),
      .rst (rst),
      .inc (win_inc),
      .max (ow),
      .cnt (ox),
      .last(ox_l)
   );

   loop1 #(.W(6)) u_oy (
      .clk (clk),
      .rst (rst),
      .inc (oy_inc),
      .max (oh),
      .cnt (oy),
      .last(oy_l)
   );

   // Running oy*iw, advanced when the output row changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         row_base <= '0;
      else if (oy_inc)
         row_base <= oy_l ? '0 : row_base + {6'd0, iw};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= nxt;
   end

   // Next state and tap issue; a tap that is the sample's last goes to DRAIN.
   always_comb begin
      nxt   = state;
      issue = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (s_init) begin
               issue = 1'b1;
               nxt   = fin_tap ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (first_tap && !win0 && out_busy) begin
               nxt = S_HOLD;
            end else begin
               issue = 1'b1;
               if (fin_tap)
                  nxt = S_DRAIN;
            end
         end
         S_HOLD: begin
            if (!out_busy) begin
               issue = 1'b1;
               nxt   = fin_tap ? S_DRAIN : S_RUN;
            end
         end
         S_DRAIN: begin
            if (s_fin)
               nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Registered tap outputs; addresses only move when a tap issues.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exec   <= 1'b0;
         k_init <= 1'b0;
         ia     <= '0;
         wa     <= '0;
      end else begin
         exec   <= issue;
         k_init <= issue & first_tap;
         if (issue) begin
            ia <= win_base + off;
            wa <= wa_nxt;
         end
      end
   end

   // MAC pipeline model: window-end and sample-end strobes delayed LAT cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ksr <= '0;
         ssr <= '0;
      end else begin
         ksr[0] <= issue & tap_last;
         ssr[0] <= issue & fin_tap;
         for (int i = 1; i <= LAT; i++) begin
            ksr[i] <= ksr[i-1];
            ssr[i] <= ssr[i-1];
         end
      end
   end

endmodule

// File: tb/tb_conv_exec_ctrl.sv
// Self-checking bench for conv_exec_ctrl: vector table, scoreboard of taps,
// k_fin/s_fin timing queue, plus hold, reset-abort and backprop sequences.
module tb_conv_exec_ctrl;
   import tiny_dnn_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_init;
   logic        out_busy;
   logic [3:0]  id;
   logic [11:0] is;
   logic [5:0]  iw;
   logic [5:0]  ow;
   logic [5:0]  oh;
   logic [3:0]  kw;
   logic [3:0]  kh;
   logic        exec;
   logic [11:0] ia;
   logic [9:0]  wa;
   logic        k_init;
   logic        k_fin;
   logic        s_fin;
   logic        busy;
`ifdef CONV_EXEC_CTRL_BACKPROP_EN
   logic        backprop;
`endif

   always #5 clk = ~clk;

   conv_exec_ctrl #(.LAT(LAT)) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef CONV_EXEC_CTRL_BACKPROP_EN
      .backprop(backprop),
`endif
      .s_init  (s_init),
      .out_busy(out_busy),
      .id      (id),
      .is      (is),
      .iw      (iw),
      .ow      (ow),
      .oh      (oh),
      .kw      (kw),
      .kh      (kh),
      .exec    (exec),
      .ia      (ia),
      .wa      (wa),
      .k_init  (k_init),
      .k_fin   (k_fin),
      .s_fin   (s_fin),
      .busy    (busy)
   );

   typedef struct {
      logic [11:0] ia;
      logic [9:0]  wa;
      logic        ki;
      logic        last;
      logic        fin;
   } tap_t;

   typedef struct {
      int   c;
      logic fin;
   } kf_t;

   typedef struct {
      int id, is, iw, ow, oh, kw, kh;
      int n_exec, n_kfin;
      int pidx, pia, pwa, pki;
   } vec_t;

   tap_t sq[$];
   kf_t  kq[$];
   tap_t e_m;
   kf_t  k_m;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_exec, n_kfin, n_sfin, n_busy;
   int exec_cyc[$];
   int ia_log[$];
   int wa_log[$];
   int ki_log[$];
   vec_t vt[4];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pop expected taps on exec, check k_fin/s_fin timing.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) n_busy++;
         if (k_fin) n_kfin++;
         if (s_fin) n_sfin++;
         if (exec) begin
            n_exec++;
            exec_cyc.push_back(cyc);
            ia_log.push_back(int'(ia));
            wa_log.push_back(int'(wa));
            ki_log.push_back(int'(k_init));
            if (sq.size() == 0) begin
               chk("exec_extra", 1, 0);
            end else begin
               e_m = sq.pop_front();
               chk("ia", int'(ia), int'(e_m.ia));
               chk("wa", int'(wa), int'(e_m.wa));
               chk("k_init", int'(k_init), int'(e_m.ki));
               if (e_m.last) begin
                  k_m.c   = cyc + LAT;
                  k_m.fin = e_m.fin;
                  kq.push_back(k_m);
               end
            end
         end else if (k_init) begin
            chk("k_init_stray", 1, 0);
         end
         if (kq.size() > 0 && kq[0].c == cyc) begin
            k_m = kq.pop_front();
            chk("k_fin", int'(k_fin), 1);
            chk("s_fin", int'(s_fin), int'(k_m.fin));
         end else begin
            if (k_fin) chk("k_fin_extra", 1, 0);
            if (s_fin) chk("s_fin_extra", 1, 0);
         end
      end
   end

   // Reference tap sequence from the closed-form address equations.
   task automatic build(input bit bp);
      int t, k, a;
      tap_t e;
      t = (int'(id) + 1) * (int'(kh) + 1) * (int'(kw) + 1);
      for (int y = 0; y <= int'(oh); y++)
         for (int x = 0; x <= int'(ow); x++) begin
            k = 0;
            for (int c = 0; c <= int'(id); c++)
               for (int r = 0; r <= int'(kh); r++)
                  for (int s = 0; s <= int'(kw); s++) begin
                     a = c * int'(is) + (y + r) * int'(iw) + x + s;
                     e.ia   = 12'(a);
                     e.wa   = bp ? 10'(t - 1 - k) : 10'(k);
                     e.ki   = (k == 0);
                     e.last = (k == t - 1);
                     e.fin  = e.last && x == int'(ow) && y == int'(oh);
                     sq.push_back(e);
                     k++;
                  end
         end
   endtask

   task automatic start(input bit bp);
      n_exec = 0;
      n_kfin = 0;
      n_sfin = 0;
      n_busy = 0;
      exec_cyc.delete();
      ia_log.delete();
      wa_log.delete();
      ki_log.delete();
      build(bp);
      @(posedge clk);
      #1 s_init = 1'b1;
      @(posedge clk);
      #1 s_init = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (n_sfin > 0 && !busy) begin
            done = 1'b1;
            break;
         end
      end
      chk("done_timeout", int'(done), 1);
      chk("sq_left", sq.size(), 0);
      chk("kq_left", kq.size(), 0);
      sq.delete();
      kq.delete();
   endtask

   task automatic set_cfg(input vec_t v);
      id = 4'(v.id);
      is = 12'(v.is);
      iw = 6'(v.iw);
      ow = 6'(v.ow);
      oh = 6'(v.oh);
      kw = 4'(v.kw);
      kh = 4'(v.kh);
   endtask

   initial begin
      vec_t hv;
      vt[0] = '{0, 0,    6,  0, 0, 0, 0, 1,   1,  0,   0,  0, 1};
      vt[1] = '{0, 36,   6,  3, 3, 2, 2, 144, 16, 61,  21, 7, 0};
      vt[2] = '{1, 36,   6,  0, 0, 2, 2, 18,  1,  9,   36, 9, 0};
      vt[3] = '{2, 4000, 63, 2, 1, 1, 2, 108, 6,  107, 0,  17, 0};

      rst      = 1'b1;
      s_init   = 1'b0;
      out_busy = 1'b0;
`ifdef CONV_EXEC_CTRL_BACKPROP_EN
      backprop = 1'b0;
`endif
      set_cfg(vt[0]);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_exec", int'(exec), 0);
      chk("rst_ia", int'(ia), 0);
      chk("rst_wa", int'(wa), 0);
      chk("rst_kfin", int'(k_fin), 0);
      chk("rst_sfin", int'(s_fin), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         set_cfg(vt[v]);
         start(1'b0);
         wait_done(5000);
         chk("n_exec", n_exec, vt[v].n_exec);
         chk("n_kfin", n_kfin, vt[v].n_kfin);
         chk("n_sfin", n_sfin, 1);
         chk("n_busy", n_busy, vt[v].n_exec + LAT);
         chk("probe_present", int'(ia_log.size() > vt[v].pidx), 1);
         if (ia_log.size() > vt[v].pidx) begin
            chk("probe_ia", ia_log[vt[v].pidx], vt[v].pia);
            chk("probe_wa", wa_log[vt[v].pidx], vt[v].pwa);
            chk("probe_kinit", ki_log[vt[v].pidx], vt[v].pki);
         end
      end

      // out_busy at the window 0->1 boundary, then briefly mid-window.
      hv = '{0, 0, 6, 1, 0, 2, 2, 18, 2, 9, 1, 0, 1};
      set_cfg(hv);
      start(1'b0);
      repeat (8) @(posedge clk);
      #1 out_busy = 1'b1;
      repeat (5) @(posedge clk);
      #1 out_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1 out_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_busy = 1'b0;
      wait_done(500);
      chk("hold_exec", n_exec, 18);
      chk("hold_kfin", n_kfin, 2);
      chk("hold_busy", n_busy, 18 + 5 + LAT);
      if (exec_cyc.size() >= 18) begin
         chk("hold_gap", exec_cyc[9] - exec_cyc[8] - 1, 5);
         chk("midwin_gap", exec_cyc[17] - exec_cyc[9], 8);
         chk("hold_w1_ia", ia_log[9], 1);
         chk("hold_w1_kinit", ki_log[9], 1);
      end else begin
         chk("hold_taps", exec_cyc.size(), 18);
      end

      // Asynchronous reset in the middle of window 0.
      hv = '{0, 0, 6, 1, 1, 2, 2, 36, 4, 0, 0, 0, 1};
      set_cfg(hv);
      start(1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_exec", int'(exec), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_exec", int'(exec), 0);
      chk("arst_ia", int'(ia), 0);
      chk("arst_wa", int'(wa), 0);
      chk("arst_kinit", int'(k_init), 0);
      chk("arst_busy", int'(busy), 0);
      sq.delete();
      kq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      n_kfin = 0;
      n_sfin = 0;
      n_exec = 0;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_kfin", n_kfin, 0);
      chk("abort_sfin", n_sfin, 0);
      chk("abort_exec", n_exec, 0);
      start(1'b0);
      wait_done(500);
      chk("restart_exec", n_exec, 36);
      chk("restart_kfin", n_kfin, 4);
      if (ia_log.size() > 0)
         chk("restart_ia0", ia_log[0], 0);
      else
         chk("restart_taps", 0, 1);

`ifdef CONV_EXEC_CTRL_BACKPROP_EN
      hv = '{0, 0, 6, 1, 0, 2, 2, 18, 2, 0, 0, 8, 1};
      set_cfg(hv);
      backprop = 1'b1;
      start(1'b1);
      wait_done(500);
      backprop = 1'b0;
      chk("bp_exec", n_exec, 18);
      if (wa_log.size() >= 18) begin
         chk("bp_wa0", wa_log[0], 8);
         chk("bp_wa8", wa_log[8], 0);
         chk("bp_wa9", wa_log[9], 8);
      end else begin
         chk("bp_taps", wa_log.size(), 18);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
